// File: rtl/softmax_pkg.sv
// Shared definitions for the pseudo_softmax tile: sequencer state type and
// default datapath widths used by the sequencer, the datapath and the tile top.
package softmax_pkg;

    localparam int unsigned SM_DW = 3;  // score / offset width
    localparam int unsigned SM_MW = 3;  // mantissa width
    localparam int unsigned SM_EW = 3;  // exponent width

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCAN,
        ISSUE,
        WAIT,
        OUT
    } seq_state_t;

endpackage

// File: rtl/softmax_seq_ctrl_if.sv
// Signal bundle between the tile pins / datapath and softmax_seq_ctrl.
//   start                      : vector start pulse
//   in_valid/in_data/in_ready  : score input stream
//   dp_in/dp_mant/dp_exp       : offset to and result from pseudo_softmax
//   out_valid/out_mant/out_exp/out_last/out_ready : result output stream
//   busy/done                  : status
// slave  : the sequencer side
// master : the surrounding logic (pins, datapath, consumer)
interface softmax_seq_ctrl_if
    import softmax_pkg::*;
#(
    parameter int unsigned DW = SM_DW,
    parameter int unsigned MW = SM_MW,
    parameter int unsigned EW = SM_EW
);
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [DW-1:0] dp_in;
    logic [MW-1:0] dp_mant;
    logic [EW-1:0] dp_exp;
    logic          out_valid;
    logic [MW-1:0] out_mant;
    logic [EW-1:0] out_exp;
    logic          out_last;
    logic          out_ready;
    logic          busy;
    logic          done;

    modport slave (
        input  start, in_valid, in_data, dp_mant, dp_exp, out_ready,
        output in_ready, dp_in, out_valid, out_mant, out_exp, out_last, busy, done
    );

    modport master (
        output start, in_valid, in_data, dp_mant, dp_exp, out_ready,
        input  in_ready, dp_in, out_valid, out_mant, out_exp, out_last, busy, done
    );
endinterface

// File: rtl/softmax_vec_buf.sv
// N_ELEM x DW score buffer: one synchronous write port and one combinational
// read port, both addressed by the sequencer's element index.
//   clk, rst : clock, async active-high reset (clears contents)
//   we       : write enable
//   idx      : element index (write and read address)
//   wdata    : score to store
//   rdata    : score at idx
module softmax_vec_buf
    import softmax_pkg::*;
#(
    parameter int unsigned N_ELEM = 4,
    parameter int unsigned DW     = SM_DW,
    localparam int unsigned IW    = $clog2(N_ELEM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [IW-1:0] idx,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [N_ELEM];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_ELEM; i++) mem[i] <= '0;
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];
endmodule

// File: rtl/softmax_seq_ctrl.sv
// Sequencer for pseudo_softmax. Loads N_ELEM scores, finds the maximum, then
// per element drives max - x to the datapath, waits DP_LAT cycles and returns
// the mantissa/exponent pair on a valid/ready output stream.
//   clk, rst : clock, async active-high reset
//   bus      : softmax_seq_ctrl_if.slave (start, input stream, datapath,
//              output stream, busy/done)
module softmax_seq_ctrl
    import softmax_pkg::*;
#(
    parameter int unsigned N_ELEM = 4,
    parameter int unsigned DW     = SM_DW,
    parameter int unsigned MW     = SM_MW,
    parameter int unsigned EW     = SM_EW,
    parameter int unsigned DP_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    softmax_seq_ctrl_if.slave   bus
);
    localparam int unsigned IW = $clog2(N_ELEM);
    localparam int unsigned CW = $clog2(DP_LAT + 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_ELEM - 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(DP_LAT - 1);

    seq_state_t    state, state_d;
    logic [IW-1:0] idx;
    logic [DW-1:0] max_q;
    logic [DW-1:0] rdata;
    logic [CW-1:0] wait_cnt;
    logic          accept;
    logic          idx_last;

    assign accept   = (state == LOAD) && bus.in_valid;
    assign idx_last = (idx == LAST_IDX);

    softmax_vec_buf #(
        .N_ELEM (N_ELEM),
        .DW     (DW)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .we     (accept),
        .idx    (idx),
        .wdata  (bus.in_data),
        .rdata  (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (bus.start) state_d = LOAD;
            LOAD:    if (accept && idx_last) state_d = SCAN;
            SCAN:    if (idx_last) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (wait_cnt == LAST_WAIT) state_d = OUT;
            OUT:     if (bus.out_ready) state_d = idx_last ? IDLE : ISSUE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx           <= '0;
            max_q         <= '0;
            wait_cnt      <= '0;
            bus.dp_in     <= '0;
            bus.out_valid <= 1'b0;
            bus.out_mant  <= '0;
            bus.out_exp   <= '0;
            bus.out_last  <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        max_q <= '0;
                        idx   <= '0;
                    end
                end
                LOAD: begin
                    if (accept) idx <= idx_last ? '0 : idx + 1'b1;
                end
                SCAN: begin
                    if (rdata > max_q) max_q <= rdata;
                    idx <= idx_last ? '0 : idx + 1'b1;
                end
                ISSUE: begin
                    // max_q >= every stored score, so the difference never wraps
                    bus.dp_in <= max_q - rdata;
                    wait_cnt  <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == LAST_WAIT) begin
                        bus.out_mant  <= bus.dp_mant;
                        bus.out_exp   <= bus.dp_exp;
                        bus.out_valid <= 1'b1;
                        bus.out_last  <= idx_last;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                        if (idx_last) begin
                            idx       <= '0;
                            bus.dp_in <= '0;
                            bus.done  <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.in_ready = (state == LOAD);
endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Self-checking bench for softmax_seq_ctrl. Two instances (DP_LAT=1 and 3)
// share the stimulus; sel chooses which one is started and observed.
module tb_softmax_seq_ctrl;
    import softmax_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = SM_DW;
    localparam int unsigned MW = SM_MW;
    localparam int unsigned EW = SM_EW;

    typedef logic [DW-1:0] vec_t [N];

    logic          clk = 1'b0;
    logic          rst;
    logic          start, in_valid, out_ready, sel;
    logic [DW-1:0] in_data;
    int            n_vec = 0;
    int            n_mis = 0;
    bit            gap_pat [7] = '{1, 0, 0, 1, 1, 0, 1};

    always #5 clk = ~clk;

    softmax_seq_ctrl_if #(.DW(DW), .MW(MW), .EW(EW)) bus1 ();
    softmax_seq_ctrl_if #(.DW(DW), .MW(MW), .EW(EW)) bus3 ();

    assign bus1.start     = start & ~sel;
    assign bus3.start     = start & sel;
    assign bus1.in_valid  = in_valid;
    assign bus3.in_valid  = in_valid;
    assign bus1.in_data   = in_data;
    assign bus3.in_data   = in_data;
    assign bus1.out_ready = out_ready;
    assign bus3.out_ready = out_ready;
    // stub datapath: mant = offset, exp = ~offset, combinational
    assign bus1.dp_mant   = bus1.dp_in;
    assign bus1.dp_exp    = ~bus1.dp_in;
    assign bus3.dp_mant   = bus3.dp_in;
    assign bus3.dp_exp    = ~bus3.dp_in;

    softmax_seq_ctrl #(.N_ELEM(N), .DW(DW), .MW(MW), .EW(EW), .DP_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1));
    softmax_seq_ctrl #(.N_ELEM(N), .DW(DW), .MW(MW), .EW(EW), .DP_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3));

    logic          o_valid, o_last, o_busy, o_done, o_inready;
    logic [MW-1:0] o_mant;
    logic [EW-1:0] o_exp;
    logic [DW-1:0] o_dp;
    int            lat;

    assign o_valid   = sel ? bus3.out_valid : bus1.out_valid;
    assign o_last    = sel ? bus3.out_last  : bus1.out_last;
    assign o_busy    = sel ? bus3.busy      : bus1.busy;
    assign o_done    = sel ? bus3.done      : bus1.done;
    assign o_inready = sel ? bus3.in_ready  : bus1.in_ready;
    assign o_mant    = sel ? bus3.out_mant  : bus1.out_mant;
    assign o_exp     = sel ? bus3.out_exp   : bus1.out_exp;
    assign o_dp      = sel ? bus3.dp_in     : bus1.dp_in;
    assign lat       = sel ? 3 : 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        logic [15:0] got1, got3;
        got1 = {bus1.out_valid, bus1.out_mant, bus1.out_exp, bus1.out_last, bus1.dp_in,
                bus1.busy, bus1.done, bus1.in_ready};
        got3 = {bus3.out_valid, bus3.out_mant, bus3.out_exp, bus3.out_last, bus3.dp_in,
                bus3.busy, bus3.done, bus3.in_ready};
        n_vec++;
        if (got1 !== '0 || got3 !== '0) begin
            n_mis++;
            $display("FAIL %s: outputs got %h/%h exp 0", name, got1, got3);
        end
    endtask

    // load_mode: 0 gapless, 1 fixed gap pattern, 2 random
    // rdy_mode : 0 always ready, 1 hold off bp_elem for 10 valid cycles, 2 random
    task automatic run_vector(input vec_t v, input int load_mode, input int rdy_mode,
                              input int bp_elem, input bit noise, input bit chained,
                              input bit chain_next);
        logic [DW-1:0] mx, e_dp, e_exp;
        logic          e_last;
        int            i, k, cyc, last_hs, held, e_gap;
        bit            first_seen;
        mx = '0;
        foreach (v[j]) if (v[j] > mx) mx = v[j];
        if (!chained) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        n_vec++;
        if (o_inready !== 1'b1 || o_busy !== 1'b1) begin
            n_mis++;
            $display("FAIL load_entry: in_ready=%b busy=%b exp 1/1", o_inready, o_busy);
        end
        i = 0;
        cyc = 0;
        while (i < int'(N) && cyc < 100) begin
            case (load_mode)
                0:       in_valid = 1'b1;
                1:       in_valid = gap_pat[cyc % 7];
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = in_valid ? v[i] : DW'($urandom);
            if (noise) start = 1'($urandom_range(0, 1));
            if (in_valid && o_inready) i++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        n_vec++;
        if (i != int'(N) || load_mode == 1 && cyc != 7) begin
            n_mis++;
            $display("FAIL load_count: accepts %0d in %0d cycles exp %0d", i, cyc, N);
        end
        n_vec++;
        if (o_inready !== 1'b0 || o_busy !== 1'b1) begin
            n_mis++;
            $display("FAIL scan_entry: in_ready=%b busy=%b exp 0/1", o_inready, o_busy);
        end

        k = 0; cyc = 0; held = 0; last_hs = 0; first_seen = 0;
        while (k < int'(N) && cyc < 400) begin
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = !(k == bp_elem && held < 10);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (noise) start = 1'($urandom_range(0, 1));
            if (o_valid === 1'b1) begin
                if (!first_seen) begin
                    first_seen = 1;
                    e_gap = (k == 0) ? int'(N) + 1 + lat : 2 + lat;
                    n_vec++;
                    if (cyc - ((k == 0) ? 0 : last_hs) != e_gap) begin
                        n_mis++;
                        $display("FAIL out_latency: elem %0d after %0d cycles exp %0d",
                                 k, cyc - ((k == 0) ? 0 : last_hs), e_gap);
                    end
                end
                e_dp   = mx - v[k];
                e_exp  = ~e_dp;
                e_last = (k == int'(N) - 1);
                n_vec++;
                if (o_dp !== e_dp || o_mant !== e_dp || o_exp !== e_exp || o_last !== e_last) begin
                    n_mis++;
                    $display("FAIL out_data: elem %0d dp/mant/exp/last got %0d/%0d/%0d/%b exp %0d/%0d/%0d/%b",
                             k, o_dp, o_mant, o_exp, o_last, e_dp, e_dp, e_exp, e_last);
                end
                if (out_ready) begin
                    k++;
                    last_hs    = cyc;
                    first_seen = 0;
                end else begin
                    held++;
                end
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        start     = chain_next;
        n_vec++;
        if (k != int'(N)) begin
            n_mis++;
            $display("FAIL out_timeout: %0d outputs exp %0d", k, N);
        end
        n_vec++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0 || o_dp !== '0) begin
            n_mis++;
            $display("FAIL done_cycle: done/busy/valid/dp got %b/%b/%b/%0d exp 1/0/0/0",
                     o_done, o_busy, o_valid, o_dp);
        end
        tick();
        start = 1'b0;
        n_vec++;
        if (chain_next) begin
            if (o_inready !== 1'b1 || o_done !== 1'b0) begin
                n_mis++;
                $display("FAIL chain_start: in_ready=%b done=%b exp 1/0", o_inready, o_done);
            end
        end else if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            n_mis++;
            $display("FAIL done_pulse: done=%b busy=%b exp 0/0", o_done, o_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset_state");
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_scan();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i + 2);
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_vec++;
        if (o_busy !== 1'b1) begin
            n_mis++;
            $display("FAIL pre_reset_busy: got %b exp 1", o_busy);
        end
        #2 rst = 1'b1;
        #1 check_all_zero("reset_async");
        tick();
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            n_vec++;
            if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
                n_mis++;
                $display("FAIL post_reset_idle: valid=%b busy=%b exp 0/0", o_valid, o_busy);
            end
        end
    endtask

    task automatic test_basic();
        vec_t v;
        v = '{3'd3, 3'd1, 3'd7, 3'd7};
        run_vector(v, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_all_equal();
        vec_t v;
        v = '{3'd5, 3'd5, 3'd5, 3'd5};
        run_vector(v, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        vec_t v;
        foreach (v[j]) v[j] = DW'($urandom);
        run_vector(v, 0, 1, 1, 0, 0, 0);
    endtask

    task automatic test_gapped_input();
        vec_t v;
        foreach (v[j]) v[j] = DW'($urandom);
        run_vector(v, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_start_noise();
        vec_t v, w;
        foreach (v[j]) v[j] = DW'($urandom);
        foreach (w[j]) w[j] = DW'($urandom);
        run_vector(v, 2, 2, 0, 1, 0, 1);
        run_vector(w, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_random(input int reps);
        vec_t v;
        for (int r = 0; r < reps; r++) begin
            foreach (v[j]) v[j] = DW'($urandom);
            run_vector(v, 2, 2, 0, 0, 0, 0);
        end
    endtask

    initial begin
        start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; sel = 1'b0; rst = 1'b1;
        test_reset();
        test_reset_mid_scan();
        test_basic();
        test_all_equal();
        test_backpressure();
        test_gapped_input();
        test_start_noise();
        test_random(5);
        sel = 1'b1;
        tick();
        test_basic();
        test_backpressure();
        test_gapped_input();
        test_random(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
